// File: rtl/anubis_sbox_layer.sv
// Anubis S-box layer: substitutes every byte of a BYTES-wide state using LANES
// combinational S-box instances, LANES bytes per cycle, behind valid/ready handshakes.

module sbox (
  input  logic [7:0] in,
  output logic [7:0] out
);

  localparam logic [7:0] SBOX_TABLE [256] = '{
    8'ha7, 8'hd3, 8'he6, 8'h71, 8'hd0, 8'hac, 8'h4d, 8'h79, 8'h3a, 8'hc9, 8'h91, 8'hfc, 8'h1e, 8'h47, 8'h54, 8'hbd,
    8'h8c, 8'ha5, 8'h7a, 8'hfb, 8'h63, 8'hb8, 8'hdd, 8'hd4, 8'he5, 8'hb3, 8'hc5, 8'hbe, 8'ha9, 8'h88, 8'h0c, 8'ha2,
    8'h39, 8'hdf, 8'h29, 8'hda, 8'h2b, 8'ha8, 8'hcb, 8'h4c, 8'h4b, 8'h22, 8'haa, 8'h24, 8'h41, 8'h70, 8'ha6, 8'hf9,
    8'h5a, 8'he2, 8'hb0, 8'h36, 8'h7d, 8'he4, 8'h33, 8'hff, 8'h60, 8'h20, 8'h08, 8'h8b, 8'h5e, 8'hab, 8'h7f, 8'h78,
    8'h7c, 8'h2c, 8'h57, 8'hd2, 8'hdc, 8'h6d, 8'h7e, 8'h0d, 8'h53, 8'h94, 8'hc3, 8'h28, 8'h27, 8'h06, 8'h5f, 8'had,
    8'h67, 8'h5c, 8'h55, 8'h48, 8'h0e, 8'h52, 8'hea, 8'h42, 8'h5b, 8'h5d, 8'h30, 8'h58, 8'h51, 8'h59, 8'h3c, 8'h4e,
    8'h38, 8'h8a, 8'h72, 8'h14, 8'he7, 8'hc6, 8'hde, 8'h50, 8'h8e, 8'h92, 8'hd1, 8'h77, 8'h93, 8'h45, 8'h9a, 8'hce,
    8'h2d, 8'h03, 8'h62, 8'hb6, 8'hb9, 8'hbf, 8'h96, 8'h6b, 8'h3f, 8'h07, 8'h12, 8'hae, 8'h40, 8'h34, 8'h46, 8'h3e,
    8'hdb, 8'hcf, 8'hec, 8'hcc, 8'hc1, 8'ha1, 8'hc0, 8'hd6, 8'h1d, 8'hf4, 8'h61, 8'h3b, 8'h10, 8'hd8, 8'h68, 8'ha0,
    8'hb1, 8'h0a, 8'h69, 8'h6c, 8'h49, 8'hfa, 8'h76, 8'hc4, 8'h9e, 8'h9b, 8'h6e, 8'h99, 8'hc2, 8'hb7, 8'h98, 8'hbc,
    8'h8f, 8'h85, 8'h1f, 8'hb4, 8'hf8, 8'h11, 8'h2e, 8'h00, 8'h25, 8'h1c, 8'h2a, 8'h3d, 8'h05, 8'h4f, 8'h7b, 8'hb2,
    8'h32, 8'h90, 8'haf, 8'h19, 8'ha3, 8'hf7, 8'h73, 8'h9d, 8'h15, 8'h74, 8'hee, 8'hca, 8'h9f, 8'h0f, 8'h1b, 8'h75,
    8'h86, 8'h84, 8'h9c, 8'h4a, 8'h97, 8'h1a, 8'h65, 8'hf6, 8'hed, 8'h09, 8'hbb, 8'h26, 8'h83, 8'heb, 8'h6f, 8'h81,
    8'h04, 8'h6a, 8'h43, 8'h01, 8'h17, 8'he1, 8'h87, 8'hf5, 8'h8d, 8'he3, 8'h23, 8'h80, 8'h44, 8'h16, 8'h66, 8'h21,
    8'hfe, 8'hd5, 8'h31, 8'hd9, 8'h35, 8'h18, 8'h02, 8'h64, 8'hf2, 8'hf1, 8'h56, 8'hcd, 8'h82, 8'hc8, 8'hba, 8'hf0,
    8'hef, 8'he9, 8'he8, 8'hfd, 8'h89, 8'hd7, 8'hc7, 8'hb5, 8'ha4, 8'h2f, 8'h95, 8'h13, 8'h0b, 8'hf3, 8'he0, 8'h37
  };

  assign out = SBOX_TABLE[in];

endmodule

module anubis_sbox_layer #(
  parameter int BYTES = 16,
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*BYTES-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*BYTES-1:0] out_data,
  output logic               busy
);

  localparam int STEPS = BYTES / LANES;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int IW    = (BYTES > 1) ? $clog2(8 * BYTES) : 3;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if ((LANES < 1) || (BYTES % LANES != 0)) begin : g_param_check
    $error("anubis_sbox_layer: LANES must divide BYTES");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic [8*BYTES-1:0] r_work;
  logic [8*BYTES-1:0] r_out;
  logic [8*BYTES-1:0] w_work_nxt;
  logic [8*LANES-1:0] w_lane_in;
  logic [8*LANES-1:0] w_lane_out;
  logic [IW-1:0]      w_base;
  logic               w_accept;
  logic               w_last;

  // Bytes handled in one step are contiguous, so the lane group is a single slice.
  assign w_base    = IW'(r_cnt) * IW'(8 * LANES);
  assign w_lane_in = r_work[w_base +: 8*LANES];
  assign w_last    = (r_state == S_BUSY) && (r_cnt == LAST);
  assign w_accept  = in_valid && in_ready;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sbox u_sbox (
      .in  (w_lane_in[8*l +: 8]),
      .out (w_lane_out[8*l +: 8])
    );
  end

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_work_nxt                     = r_work;
    w_work_nxt[w_base +: 8*LANES] = w_lane_out;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        busy = 1'b1;
        if (r_cnt == LAST) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) w_state_nxt = in_valid ? S_BUSY : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cnt <= '0;
      end else if ((r_state == S_BUSY) && (r_cnt != LAST)) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_last) r_out <= w_work_nxt;
    end
  end

  // NOTE: the working register is pure datapath, always reloaded on accept, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_work <= in_data;
    end else if (r_state == S_BUSY) begin
      r_work <= w_work_nxt;
    end
  end

  assign out_data = r_out;

endmodule
